ysyx_23060180_mem_resp: RTL and testbench

Memory responder on the far end of the core's fetch port (mem_rd/mem_raddr/mem_rdata). It also serves a word write port for store traffic and a preload port used by the simulation loader.
- Word-organised on-chip memory mapped at BASE_ADDR.
- Reads return data at a fixed latency through a delay pipeline.
- Byte-strobed writes.
- Out-of-range accesses are flagged.

---
 rtl/ysyx_23060180_pkg.sv | 25 ++
 rtl/ysyx_23060180_mem_resp_if.sv | 32 +++
 rtl/ysyx_23060180_rd_pipe.sv | 46 ++++
 rtl/ysyx_23060180_mem_resp.sv | 104 ++++++++++
 tb/tb_ysyx_23060180_mem_resp.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060180_pkg.sv
// Shared definitions for the ysyx_23060180 core slice: data width,
// reset PC, strobe width, the read-response record and address helpers.
package ysyx_23060180_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    localparam int STRB_W = XLEN / 8;

    // One read response as it travels down the latency pipeline.
    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] data;
    } rd_resp_t;

    // Word offset of a byte address from a base. Addresses below the base
    // wrap to a huge offset, so a plain "< depth" test rejects them too.
    function automatic logic [XLEN-1:0] word_offset(input logic [XLEN-1:0] addr,
                                                    input logic [XLEN-1:0] base);
        logic [XLEN-1:0] diff;
        diff = addr - base;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/ysyx_23060180_mem_resp_if.sv
// Bus bundle between the core (master) and the memory responder (slave):
// fetch read port, store write port and the loader preload port.
interface ysyx_23060180_mem_resp_if;
    import ysyx_23060180_pkg::*;

    logic              mem_rd;
    logic [XLEN-1:0]   mem_raddr;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_rvalid;
    logic              mem_rerr;
    logic              mem_wr;
    logic [XLEN-1:0]   mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_werr;
    logic              init_wr;
    logic [XLEN-1:0]   init_addr;
    logic [XLEN-1:0]   init_data;

    modport master (
        output mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata, mem_wstrb,
               init_wr, init_addr, init_data,
        input  mem_rdata, mem_rvalid, mem_rerr, mem_werr
    );

    modport slave (
        input  mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata, mem_wstrb,
               init_wr, init_addr, init_data,
        output mem_rdata, mem_rvalid, mem_rerr, mem_werr
    );

endinterface

// File: rtl/ysyx_23060180_rd_pipe.sv
// Fixed-latency delay line for read responses. The last stage is the
// registered output; its data only changes when a valid response arrives.
module ysyx_23060180_rd_pipe
    import ysyx_23060180_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rd_resp_t in_resp,
    output rd_resp_t out_resp
);

    rd_resp_t src     [RD_LAT];
    rd_resp_t stage_d [RD_LAT];
    rd_resp_t stage_q [RD_LAT];

    // Shift every stage from its predecessor; data moves only with a valid bit.
    always_comb begin
        src[0] = in_resp;
        for (int i = 1; i < RD_LAT; i++) begin
            src[i] = stage_q[i-1];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            stage_d[i].valid = src[i].valid;
            stage_d[i].err   = src[i].valid & src[i].err;
            stage_d[i].data  = src[i].valid ? src[i].data : stage_q[i].data;
        end
    end

    // Reset wipes every stage so reads in flight never produce a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_resp = stage_q[RD_LAT-1];

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Word-organised memory responder behind the core's fetch port. Serves
// fixed-latency reads, byte-strobed stores and full-word loader writes,
// flagging out-of-range reads and stores.
module ysyx_23060180_mem_resp
    import ysyx_23060180_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR   = RESET_PC,
    parameter int              DEPTH_WORDS = 4096,
    parameter int              RD_LAT      = 1,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'h0
) (
    input logic                     clk,
    input logic                     rst_in,
    ysyx_23060180_mem_resp_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(DEPTH_WORDS);

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic [XLEN-1:0]   r_woff;
    logic [XLEN-1:0]   w_woff;
    logic [XLEN-1:0]   i_woff;
    logic              rd_ok;
    logic              wr_ok;
    logic              init_ok;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [STRB_W-1:0] wr_be;
    logic [XLEN-1:0]   wr_data;
    logic              werr_d;
    logic              werr_q;
    rd_resp_t          pipe_in;
    rd_resp_t          pipe_out;

    // Decode all three ports and pick the single array write for this cycle;
    // the loader wins over a store, and a displaced store is dropped quietly.
    always_comb begin
        r_woff  = word_offset(bus.mem_raddr, BASE_ADDR);
        w_woff  = word_offset(bus.mem_waddr, BASE_ADDR);
        i_woff  = word_offset(bus.init_addr, BASE_ADDR);
        rd_ok   = (bus.mem_raddr >= BASE_ADDR) && (r_woff < DEPTH_LIM);
        wr_ok   = (bus.mem_waddr >= BASE_ADDR) && (w_woff < DEPTH_LIM);
        init_ok = (bus.init_addr >= BASE_ADDR) && (i_woff < DEPTH_LIM);

        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_be   = '0;
        wr_data = '0;
        werr_d  = 1'b0;
        if (bus.init_wr) begin
            wr_en   = init_ok;
            wr_idx  = i_woff[IDX_W-1:0];
            wr_be   = '1;
            wr_data = bus.init_data;
        end else if (bus.mem_wr) begin
            wr_en   = wr_ok;
            wr_idx  = w_woff[IDX_W-1:0];
            wr_be   = bus.mem_wstrb;
            wr_data = bus.mem_wdata;
            werr_d  = ~wr_ok;
        end

        pipe_in.valid = bus.mem_rd;
        pipe_in.err   = ~rd_ok;
        pipe_in.data  = rd_ok ? mem_q[r_woff[IDX_W-1:0]] : ERR_DATA;
    end

    // Byte-enabled array update; the array has no reset so contents survive rst_in.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // One-cycle store error pulse following an out-of-range store.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= werr_d;
        end
    end

    ysyx_23060180_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst_in),
        .in_resp  (pipe_in),
        .out_resp (pipe_out)
    );

    assign bus.mem_rvalid = pipe_out.valid;
    assign bus.mem_rerr   = pipe_out.err;
    assign bus.mem_rdata  = pipe_out.data;
    assign bus.mem_werr   = werr_q;

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
// Self-checking bench: two responders (latency 1 and 3) share one stimulus
// stream and are compared every cycle against a word-level memory model.
module tb_ysyx_23060180_mem_resp;
    import ysyx_23060180_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          err;
        bit          known;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv_rd;
    logic [31:0] drv_raddr;
    logic        drv_wr;
    logic [31:0] drv_waddr;
    logic [31:0] drv_wdata;
    logic [3:0]  drv_wstrb;
    logic        drv_iwr;
    logic [31:0] drv_iaddr;
    logic [31:0] drv_idata;

    resp_t       q1[$];
    resp_t       q3[$];
    logic [31:0] mm [int unsigned];
    logic [31:0] last1;
    logic [31:0] last3;
    bit          last1_known;
    bit          last3_known;
    bit          exp_werr;
    int          edge_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ysyx_23060180_mem_resp_if bus1();
    ysyx_23060180_mem_resp_if bus3();

    assign bus1.mem_rd    = drv_rd;
    assign bus1.mem_raddr = drv_raddr;
    assign bus1.mem_wr    = drv_wr;
    assign bus1.mem_waddr = drv_waddr;
    assign bus1.mem_wdata = drv_wdata;
    assign bus1.mem_wstrb = drv_wstrb;
    assign bus1.init_wr   = drv_iwr;
    assign bus1.init_addr = drv_iaddr;
    assign bus1.init_data = drv_idata;
    assign bus3.mem_rd    = drv_rd;
    assign bus3.mem_raddr = drv_raddr;
    assign bus3.mem_wr    = drv_wr;
    assign bus3.mem_waddr = drv_waddr;
    assign bus3.mem_wdata = drv_wdata;
    assign bus3.mem_wstrb = drv_wstrb;
    assign bus3.init_wr   = drv_iwr;
    assign bus3.init_addr = drv_iaddr;
    assign bus3.init_data = drv_idata;

    ysyx_23060180_mem_resp #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .ERR_DATA(32'h0)
    ) dut1 (
        .clk(clk), .rst_in(rst), .bus(bus1)
    );

    ysyx_23060180_mem_resp #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(3), .ERR_DATA(32'h0)
    ) dut3 (
        .clk(clk), .rst_in(rst), .bus(bus3)
    );

    // Address is valid when it lies in [BASE, BASE + 4*DEPTH), computed in 64 bits.
    function automatic bit inRange(input logic [31:0] a);
        longint unsigned la;
        longint unsigned lo;
        longint unsigned hi;
        la = 64'(a);
        lo = 64'(BASE);
        hi = lo + 64'(4 * DEPTH);
        return (la >= lo) && (la < hi);
    endfunction

    function automatic int unsigned wordOf(input logic [31:0] a);
        return int'((64'(a) - 64'(BASE)) / 4);
    endfunction

    // Mostly a small preloaded window (with junk in the low bits), sometimes edge or wild addresses.
    function automatic logic [31:0] pickAddr();
        int unsigned sel;
        sel = $urandom_range(0, 99);
        if (sel < 85) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        else if (sel < 89) return 32'h7FFF_FFFC;
        else if (sel < 93) return 32'h8000_4000;
        else if (sel < 97) return 32'h8000_3FFC;
        else return $urandom;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compareResp(input string nm, input bit expValid, input resp_t r,
                               input logic gotValid, input logic gotErr, input logic [31:0] gotData,
                               inout logic [31:0] lastData, inout bit lastKnown);
        checkOutput({nm, ".rvalid"}, 32'(gotValid), 32'(expValid));
        if (expValid) begin
            checkOutput({nm, ".rerr"}, 32'(gotErr), 32'(r.err));
            lastKnown = r.known;
            lastData  = r.data;
        end
        if (lastKnown) checkOutput({nm, ".rdata"}, gotData, lastData);
    endtask

    // Compare both responders against the model just after an edge has settled.
    task automatic checkAll();
        resp_t r;
        bit    v;
        r = '{due: 0, data: 32'h0, err: 1'b0, known: 1'b0};
        v = 1'b0;
        if (q1.size() > 0) begin
            if (q1[0].due == edge_cnt) begin
                v = 1'b1;
                r = q1.pop_front();
            end
        end
        compareResp("lat1", v, r, bus1.mem_rvalid, bus1.mem_rerr, bus1.mem_rdata, last1, last1_known);
        r = '{due: 0, data: 32'h0, err: 1'b0, known: 1'b0};
        v = 1'b0;
        if (q3.size() > 0) begin
            if (q3[0].due == edge_cnt) begin
                v = 1'b1;
                r = q3.pop_front();
            end
        end
        compareResp("lat3", v, r, bus3.mem_rvalid, bus3.mem_rerr, bus3.mem_rdata, last3, last3_known);
        checkOutput("lat1.werr", 32'(bus1.mem_werr), 32'(exp_werr));
        checkOutput("lat3.werr", 32'(bus3.mem_werr), 32'(exp_werr));
    endtask

    // Drive one cycle of inputs at a falling edge, update the model at the rising edge, check at the next fall.
    task automatic applyStimulus(input logic rd, input logic [31:0] raddr,
                                 input logic wr, input logic [31:0] waddr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic iwr, input logic [31:0] iaddr, input logic [31:0] idata);
        resp_t       r;
        logic [31:0] t;
        drv_rd = rd; drv_raddr = raddr;
        drv_wr = wr; drv_waddr = waddr; drv_wdata = wdata; drv_wstrb = wstrb;
        drv_iwr = iwr; drv_iaddr = iaddr; drv_idata = idata;
        @(posedge clk);
        edge_cnt++;
        if (rd) begin
            r.err   = !inRange(raddr);
            r.known = 1'b1;
            r.data  = 32'h0;
            if (!r.err) begin
                if (mm.exists(wordOf(raddr))) r.data = mm[wordOf(raddr)];
                else r.known = 1'b0;
            end
            r.due = edge_cnt;
            q1.push_back(r);
            r.due = edge_cnt + 2;
            q3.push_back(r);
        end
        exp_werr = 1'b0;
        if (iwr) begin
            if (inRange(iaddr)) mm[wordOf(iaddr)] = idata;
        end else if (wr) begin
            if (!inRange(waddr)) begin
                exp_werr = 1'b1;
            end else if (mm.exists(wordOf(waddr))) begin
                t = mm[wordOf(waddr)];
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) t[8*b +: 8] = wdata[8*b +: 8];
                end
                mm[wordOf(waddr)] = t;
            end else if (wstrb == 4'hF) begin
                mm[wordOf(waddr)] = wdata;
            end
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic doRead(input logic [31:0] a);
        applyStimulus(1, a, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        applyStimulus(0, 32'h0, 1, a, d, s, 0, 32'h0, 32'h0);
    endtask

    task automatic doInit(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1, a, d);
    endtask

    // Assert reset asynchronously at a falling edge, hold it for n rising edges, then release.
    task automatic doReset(input int n);
        drv_rd = 0; drv_wr = 0; drv_iwr = 0;
        rst = 1'b1;
        q1.delete();
        q3.delete();
        last1 = 32'h0; last1_known = 1'b1;
        last3 = 32'h0; last3_known = 1'b1;
        exp_werr = 1'b0;
        #1;
        checkOutput("reset.lat1.rdata", bus1.mem_rdata, 32'h0);
        checkOutput("reset.lat3.rdata", bus3.mem_rdata, 32'h0);
        checkOutput("reset.lat3.rvalid", 32'(bus3.mem_rvalid), 32'h0);
        repeat (n) begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            checkAll();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] wa;
        logic [3:0]  ws;
        rst = 1'b0;
        drv_rd = 0; drv_raddr = 0; drv_wr = 0; drv_waddr = 0; drv_wdata = 0;
        drv_wstrb = 0; drv_iwr = 0; drv_iaddr = 0; drv_idata = 0;
        #2;
        @(negedge clk);
        doReset(3);
        idle();

        for (int i = 0; i < 16; i++) doInit(BASE + 32'(4 * i), $urandom);

        doInit(32'h8000_0000, 32'h0010_0093);
        doInit(32'h8000_0004, 32'h0010_0073);
        doRead(32'h8000_0000);
        checkOutput("preload0.rdata", bus1.mem_rdata, 32'h0010_0093);
        checkOutput("preload0.rerr", 32'(bus1.mem_rerr), 32'h0);
        doRead(32'h8000_0004);
        checkOutput("preload1.rdata", bus1.mem_rdata, 32'h0010_0073);
        checkOutput("preload1.rvalid", 32'(bus1.mem_rvalid), 32'h1);

        doInit(32'h8000_0010, 32'h1122_3344);
        doWrite(32'h8000_0010, 32'hAABB_CCDD, 4'b0101);
        doRead(32'h8000_0010);
        checkOutput("strobe.rdata", bus1.mem_rdata, 32'h11BB_33DD);
        doWrite(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
        checkOutput("strobe0.werr", 32'(bus1.mem_werr), 32'h0);
        doRead(32'h8000_0010);
        checkOutput("strobe0.rdata", bus1.mem_rdata, 32'h11BB_33DD);

        doInit(32'h8000_0020, 32'h0);
        applyStimulus(1, 32'h8000_0020, 1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 32'h0);
        checkOutput("collide.old", bus1.mem_rdata, 32'h0);
        doRead(32'h8000_0020);
        checkOutput("collide.new", bus1.mem_rdata, 32'hCAFE_F00D);

        doRead(32'h7FFF_FFFC);
        checkOutput("range.low.rerr", 32'(bus1.mem_rerr), 32'h1);
        checkOutput("range.low.rdata", bus1.mem_rdata, 32'h0);
        doRead(32'h8000_4000);
        checkOutput("range.high.rvalid", 32'(bus1.mem_rvalid), 32'h1);
        checkOutput("range.high.rerr", 32'(bus1.mem_rerr), 32'h1);
        doInit(32'h8000_3FFC, 32'h5A5A_1234);
        doRead(32'h8000_3FFC);
        checkOutput("range.last.rdata", bus1.mem_rdata, 32'h5A5A_1234);
        checkOutput("range.last.rerr", 32'(bus1.mem_rerr), 32'h0);
        doWrite(32'h8000_4000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("range.werr.pulse", 32'(bus1.mem_werr), 32'h1);
        idle();
        checkOutput("range.werr.clear", 32'(bus1.mem_werr), 32'h0);
        doRead(32'h8000_0000);
        checkOutput("range.unchanged", bus1.mem_rdata, 32'h0010_0093);
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h8000_4000, 32'h1234_5678);
        checkOutput("range.init.noerr", 32'(bus1.mem_werr), 32'h0);

        applyStimulus(0, 32'h0, 1, 32'h8000_0008, 32'h2, 4'hF, 1, 32'h8000_0008, 32'h1);
        doRead(32'h8000_0008);
        checkOutput("priority.rdata", bus1.mem_rdata, 32'h1);

        for (int i = 0; i < 400; i++) begin
            ra = pickAddr();
            wa = pickAddr();
            ws = 4'($urandom);
            if (!inRange(wa) && ws == 4'h0) ws = 4'hF;
            applyStimulus($urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, wa, $urandom, ws,
                          $urandom_range(0, 7) == 0, pickAddr(), $urandom);
        end
        repeat (3) idle();

        doInit(32'h8000_0000, 32'h0010_0093);
        doRead(32'h8000_0004);
        idle();
        doReset(2);
        checkOutput("rstmid.lat3.rvalid", 32'(bus3.mem_rvalid), 32'h0);
        checkOutput("rstmid.lat3.rdata", bus3.mem_rdata, 32'h0);
        repeat (4) idle();
        doRead(32'h8000_0000);
        idle();
        idle();
        checkOutput("rstmid.reload.rvalid", 32'(bus3.mem_rvalid), 32'h1);
        checkOutput("rstmid.reload.rdata", bus3.mem_rdata, 32'h0010_0093);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
